// File: rtl/fp16_pkg.sv
// -----------------------------------------------------------------------------
// fp16_pkg
//   Shared definitions for the binary16 add stage: field widths, special
//   encodings, the unpacked-operand struct and the operand unpack helper.
//   No ports.
// -----------------------------------------------------------------------------
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;

    // All-ones exponent marks Inf/NaN.
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;     // effective exponent: subnormals read as 1
        logic [FRAC_W:0]   sig;     // hidden bit + fraction
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } fp16_unpacked_t;

    // flip inverts the sign, which turns a subtraction into an addition.
    function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] x, input logic flip);
        fp16_unpacked_t u;
        logic exp_nz;
        logic frac_nz;
        exp_nz    = |x[14:10];
        frac_nz   = |x[9:0];
        u.sign    = x[15] ^ flip;
        u.exp     = exp_nz ? x[14:10] : EXP_W'(1);
        u.sig     = {exp_nz, x[9:0]};
        u.is_nan  = (x[14:10] == EXP_MAX) & frac_nz;
        u.is_inf  = (x[14:10] == EXP_MAX) & ~frac_nz;
        u.is_zero = ~exp_nz & ~frac_nz;
        return u;
    endfunction

endpackage

// File: rtl/fp16_adder_if.sv
// -----------------------------------------------------------------------------
// fp16_adder_if
//   Operand/result bundle of the binary16 add stage.
//   master: drives in_valid, op_sub, a, b; receives out_valid, result.
//   slave : the adder itself.
// -----------------------------------------------------------------------------
interface fp16_adder_if;

    logic        in_valid;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [15:0] result;

    modport master (
        output in_valid, op_sub, a, b,
        input  out_valid, result
    );

    modport slave (
        input  in_valid, op_sub, a, b,
        output out_valid, result
    );

endinterface

// File: rtl/fp16_lzc.sv
// -----------------------------------------------------------------------------
// fp16_lzc
//   14-bit leading-zero counter for post-add normalisation.
//   value : in  14  significand with guard/round/sticky
//   count : out 4   number of leading zeros (14 when value is zero)
// -----------------------------------------------------------------------------
module fp16_lzc (
    input  logic [13:0] value,
    output logic [3:0]  count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (value[i]) begin
                count = 4'(13 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_adder.sv
// -----------------------------------------------------------------------------
// fp16_adder
//   IEEE 754 binary16 adder/subtractor, round-to-nearest-even, full subnormal,
//   Inf and NaN handling. Combinational datapath into one output register,
//   latency 1, one operation accepted per cycle.
//   clk   : in   rising-edge clock
//   rst_n : in   asynchronous active-low reset (clears result and out_valid)
//   bus   : fp16_adder_if.slave -- in_valid, op_sub, a, b in; out_valid, result out
// -----------------------------------------------------------------------------
module fp16_adder
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fp16_adder_if.slave       bus
);

    // Pack an 11-bit significand window plus G/R/S with RNE.
    // Adding the round increment to {exp, frac} lets a carry ripple into the
    // exponent, which covers mantissa overflow, subnormal->normal promotion
    // and overflow to Inf in one step.
    function automatic logic [15:0] round_pack(input logic       sign,
                                               input logic [5:0] e,
                                               input logic [13:0] m);
        logic [5:0]  e_enc;
        logic        up;
        logic [15:0] packed_mag;
        e_enc      = m[13] ? e : 6'd0;
        up         = m[2] & (m[1] | m[0] | m[3]);
        packed_mag = {e_enc, m[12:3]} + {15'd0, up};
        if (packed_mag[15:10] >= {1'b0, EXP_MAX}) begin
            return sign ? FP16_NINF : FP16_PINF;
        end
        return {sign, packed_mag[14:0]};
    endfunction

    fp16_unpacked_t ua;
    fp16_unpacked_t ub;

    assign ua = fp16_unpack(bus.a, 1'b0);
    assign ub = fp16_unpack(bus.b, bus.op_sub);

    logic        a_ge_b;
    logic        eff_sub;
    logic        big_sign;
    logic [4:0]  big_exp;
    logic [10:0] big_sig;
    logic [4:0]  small_exp;
    logic [10:0] small_sig;
    logic [4:0]  exp_diff;
    logic [26:0] small_ext;
    logic [26:0] shifted;
    logic [13:0] big_al;
    logic [13:0] small_al;
    logic [14:0] mag;
    logic [3:0]  lz;
    logic [4:0]  shift_cap;
    logic [4:0]  shift;
    logic [13:0] norm_m;
    logic [5:0]  norm_e;
    logic [15:0] res_next;

    // Raw {exp, frac} compare orders magnitudes, subnormals included.
    assign a_ge_b  = bus.a[14:0] >= bus.b[14:0];
    assign eff_sub = ua.sign ^ ub.sign;

    always_comb begin
        big_sign  = a_ge_b ? ua.sign : ub.sign;
        big_exp   = a_ge_b ? ua.exp  : ub.exp;
        big_sig   = a_ge_b ? ua.sig  : ub.sig;
        small_exp = a_ge_b ? ub.exp  : ua.exp;
        small_sig = a_ge_b ? ub.sig  : ua.sig;
        exp_diff  = big_exp - small_exp;

        // Align: the 16 zero bits below the significand catch everything
        // shifted past R, folded into S. A shift of 14 or more leaves only S.
        small_ext = {small_sig, 16'd0};
        shifted   = small_ext >> exp_diff;
        if (exp_diff >= 5'd14) begin
            small_al = {13'd0, |small_sig};
        end else begin
            small_al = {shifted[26:14], shifted[13] | (|shifted[12:0])};
        end
        big_al = {big_sig, 3'b000};

        // |big| >= |small| so the difference never goes negative.
        if (eff_sub) begin
            mag = {1'b0, big_al} - {1'b0, small_al};
        end else begin
            mag = {1'b0, big_al} + {1'b0, small_al};
        end
    end

    fp16_lzc u_lzc (
        .value (mag[13:0]),
        .count (lz)
    );

    always_comb begin
        shift_cap = big_exp - 5'd1;
        shift     = 5'd0;
        if (mag[14]) begin
            // Carry-out: one right shift, the dropped bit joins sticky.
            norm_m = {mag[14:2], mag[1] | mag[0]};
            norm_e = {1'b0, big_exp} + 6'd1;
        end else begin
            // Left shift stops at exponent 1; anything smaller stays subnormal.
            shift  = ({1'b0, lz} > shift_cap) ? shift_cap : {1'b0, lz};
            norm_m = mag[13:0] << shift;
            norm_e = {1'b0, big_exp} - {1'b0, shift};
        end

        if (ua.is_nan | ub.is_nan) begin
            res_next = FP16_QNAN;
        end else if (ua.is_inf & ub.is_inf & eff_sub) begin
            res_next = FP16_QNAN;
        end else if (ua.is_inf) begin
            res_next = ua.sign ? FP16_NINF : FP16_PINF;
        end else if (ub.is_inf) begin
            res_next = ub.sign ? FP16_NINF : FP16_PINF;
        end else if (ua.is_zero & ub.is_zero) begin
            // Only (-0)+(-0) keeps a negative sign.
            res_next = {ua.sign & ub.sign, 15'd0};
        end else if (mag == 15'd0) begin
            // Exact cancellation of non-zero operands gives +0.
            res_next = 16'h0000;
        end else begin
            res_next = round_pack(big_sign, norm_e, norm_m);
        end
    end

    // ---- stage p1: output register ----
    logic [15:0] result_p1;
    logic        vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= 16'h0000;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                result_p1 <= res_next;
            end
        end
    end

    assign bus.result    = result_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_fp16_adder.sv
// -----------------------------------------------------------------------------
// tb_fp16_adder
//   Bench for fp16_adder: directed vectors with literal expectations, a
//   rational-value reference model, random operands and control checks.
// -----------------------------------------------------------------------------
module tb_fp16_adder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int errors = 0;
    int checks = 0;

    fp16_adder_if bus ();

    fp16_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Magnitude of a finite binary16 as an integer count of 2^-24.
    function automatic longint fp_mag(input logic [15:0] x);
        int e;
        longint f;
        e = int'(x[14:10]);
        f = longint'(x[9:0]);
        if (e == 0) return f;
        return (f + 64'd1024) << (e - 1);
    endfunction

    // Reference: exact sum in 2^-24 units, then RNE back to binary16.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub);
        logic   sa, sb, a_nan, b_nan, a_inf, b_inf, sign;
        longint va, vb, s, m, q, rem, half;
        int     p, e_unb, k;
        sa    = a[15];
        sb    = b[15] ^ sub;
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        if (a_nan || b_nan) return 16'h7E00;
        if (a_inf && b_inf) return (sa != sb) ? 16'h7E00 : {sa, 15'h7C00};
        if (a_inf) return {sa, 15'h7C00};
        if (b_inf) return {sb, 15'h7C00};
        va = fp_mag(a);
        vb = fp_mag(b);
        s  = (sa ? -va : va) + (sb ? -vb : vb);
        if (s == 0) begin
            if (va == 0 && vb == 0) return {sa & sb, 15'd0};
            return 16'h0000;
        end
        sign = (s < 0);
        m    = sign ? -s : s;
        p    = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        e_unb = p - 24;
        if (e_unb < -14) e_unb = -14;
        k    = e_unb + 14;
        q    = m >> k;
        rem  = m - (q << k);
        half = (k > 0) ? (64'sd1 <<< (k - 1)) : 64'sd0;
        if (k > 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
        if (q == 2048) begin
            q     = 1024;
            e_unb = e_unb + 1;
        end
        if (q < 1024) return {sign, 5'd0, q[9:0]};
        if (e_unb + 15 >= 31) return {sign, 15'h7C00};
        return {sign, 5'(e_unb + 15), q[9:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Model of the registered outputs, advanced by the same edges as the DUT.
    logic [15:0] m_res = 16'h0000;
    logic        m_vld = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res = 16'h0000;
            m_vld = 1'b0;
        end else begin
            m_vld = bus.in_valid;
            if (bus.in_valid) m_res = ref_add(bus.a, bus.b, bus.op_sub);
        end
    end

    // Outputs are defined every cycle (valid flag always, result held).
    always @(negedge clk) begin
        check("model_vld", {15'd0, bus.out_valid}, {15'd0, m_vld});
        check("model_res", bus.result, m_res);
    end

    task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [15:0] expv);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_sub   = sub;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        check(name, bus.result, expv);
        check({name, "_vld"}, {15'd0, bus.out_valid}, 16'd1);
        check({name, "_ref"}, ref_add(a, b, sub), expv);
    endtask

    initial begin
        logic [4:0] eb;
        bus.in_valid = 1'b0;
        bus.op_sub   = 1'b0;
        bus.a        = 16'h0000;
        bus.b        = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_res", bus.result, 16'h0000);
        check("reset_vld", {15'd0, bus.out_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("one_plus_one",   16'h3C00, 16'h3C00, 1'b0, 16'h4000);
        apply("cancel_add",     16'h3C00, 16'hBC00, 1'b0, 16'h0000);
        apply("neg0_plus_neg0", 16'h8000, 16'h8000, 1'b0, 16'h8000);
        apply("pos0_plus_neg0", 16'h0000, 16'h8000, 1'b0, 16'h0000);
        apply("cancel_sub",     16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        apply("tie_even",       16'h3C00, 16'h1000, 1'b0, 16'h3C00);
        apply("tie_up",         16'h3C01, 16'h1000, 1'b0, 16'h3C02);
        apply("overflow",       16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
        apply("inf_minus_inf",  16'h7C00, 16'hFC00, 1'b0, 16'h7E00);
        apply("inf_plus_fin",   16'h7C00, 16'h3C00, 1'b0, 16'h7C00);
        apply("fin_sub_inf",    16'h3C00, 16'h7C00, 1'b1, 16'hFC00);
        apply("nan_in",         16'h7D00, 16'h3C00, 1'b0, 16'h7E00);
        apply("sub_plus_sub",   16'h0001, 16'h0001, 1'b0, 16'h0002);
        apply("sub_to_norm",    16'h03FF, 16'h0001, 1'b0, 16'h0400);
        apply("norm_to_sub",    16'h0400, 16'h0001, 1'b1, 16'h03FF);
        apply("one_minus_half", 16'h3C00, 16'h3800, 1'b1, 16'h3800);

        // Idle cycle: valid drops, result keeps the last value.
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 16'h1234;
        bus.b        = 16'h5678;
        @(posedge clk);
        #1;
        check("idle_vld",  {15'd0, bus.out_valid}, 16'd0);
        check("idle_hold", bus.result, 16'h3800);

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if (n == 5000) begin
                // Asynchronous reset between edges clears the outputs at once.
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_res", bus.result, 16'h0000);
                check("async_rst_vld", {15'd0, bus.out_valid}, 16'd0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            bus.in_valid = ($urandom_range(0, 7) != 0);
            bus.op_sub   = 1'($urandom_range(0, 1));
            bus.a        = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                eb    = bus.a[14:10] + 5'($urandom_range(0, 2)) - 5'd1;
                bus.b = {1'($urandom_range(0, 1)), eb, 10'($urandom)};
            end else begin
                bus.b = 16'($urandom);
            end
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
